// File: rtl/vga_dither_pwm_if.sv
// Pixel/sync bundle between the video mixer and the VGA colour-depth reducer.
// The master side drives the wide pixel stream and syncs. The slave side
// returns the reduced pixel and the delayed syncs.
interface vga_dither_pwm_if #(
  parameter int CH    = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 6
);
  logic                  ce_pix;
  logic [1:0]            mode;
  logic                  csync_en;
  logic                  hsync;
  logic                  vsync;
  logic                  csync;
  logic                  de;
  logic [CH*IN_W-1:0]    din;
  logic [CH*OUT_W-1:0]   dout;
  logic                  hs_out;
  logic                  vs_out;
  logic                  cs_out;
  logic                  de_out;

  modport master (
    output ce_pix, mode, csync_en, hsync, vsync, csync, de, din,
    input  dout, hs_out, vs_out, cs_out, de_out
  );

  modport slave (
    input  ce_pix, mode, csync_en, hsync, vsync, csync, de, din,
    output dout, hs_out, vs_out, cs_out, de_out
  );
endinterface

// File: rtl/vga_dither_pwm.sv
// Colour-depth reducer for the VGA DAC path. It keeps the top OUT_W bits of
// each channel. The D = IN_W-OUT_W discarded bits are folded back in as a
// conditional +1, compared against a threshold. The threshold comes from
// truncation, a per-line PWM, a 4x4 Bayer matrix, or a Bayer matrix rotated
// every frame. Syncs and de go through the same single register stage, so
// they stay aligned with the pixels.
module vga_dither_pwm #(
  parameter int CH    = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  vga_dither_pwm_if.slave bus
);

  localparam int D = IN_W - OUT_W;

  // Reject widths the threshold logic cannot represent.
  generate
    if (D < 1 || D > 4) begin : g_bad_width
      $error("vga_dither_pwm: IN_W-OUT_W must be in 1..4");
    end
    if (CH < 1 || CH > 4) begin : g_bad_ch
      $error("vga_dither_pwm: CH must be in 1..4");
    end
  endgenerate

  // 4x4 ordered-dither matrix, indexed by line (y) and pixel (x) phase.
  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] b;
    case ({y, x})
      4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
      4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
      4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
      4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  default: b = 4'd5;
    endcase
    return b;
  endfunction

  // Round up by one when the residue beats the threshold, but never past
  // full scale: a wrap to zero would show as a black speck on white.
  function automatic logic [OUT_W-1:0] dither_sat(input logic [OUT_W-1:0] q,
                                                  input logic [D-1:0]     r,
                                                  input logic [D-1:0]     t);
    if ((r > t) && !(&q)) return q + OUT_W'(1);
    return q;
  endfunction

  // Previous sync levels for rising-edge detection.
  logic r_hs_prev;
  logic r_vs_prev;
  logic r_cs_prev;

  // Dither phase counters.
  logic [3:0] r_lcnt;
  logic [3:0] r_fcnt;
  logic [1:0] r_pcnt;

  // Output stage registers.
  logic [CH*OUT_W-1:0] r_dout_p1;
  logic                r_hs_p1;
  logic                r_vs_p1;
  logic                r_cs_p1;
  logic                r_vld_p1;

  logic                w_hs_rise;
  logic                w_vs_rise;
  logic                w_cs_rise;
  logic                w_lsync_rise;
  logic [3:0]          w_bayer;
  logic [D-1:0]        w_bd;
  logic [D-1:0]        w_thr;
  logic [CH*OUT_W-1:0] w_pix;

  assign w_hs_rise    = bus.hsync & ~r_hs_prev;
  assign w_vs_rise    = bus.vsync & ~r_vs_prev;
  assign w_cs_rise    = bus.csync & ~r_cs_prev;
  // The line clock comes from csync on composite-sync monitors, otherwise from hsync.
  assign w_lsync_rise = bus.csync_en ? w_cs_rise : w_hs_rise;

  // Capture sync levels so that the next clock can see their rising edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_cs_prev <= 1'b0;
    end else begin
      r_hs_prev <= bus.hsync;
      r_vs_prev <= bus.vsync;
      r_cs_prev <= bus.csync;
    end
  end

  // Line and frame counters. A vsync edge restarts the line phase, and this
  // clear overrides a line edge that arrives on the same clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lcnt <= 4'd0;
      r_fcnt <= 4'd0;
    end else begin
      if (w_vs_rise) begin
        r_lcnt <= 4'd0;
        r_fcnt <= r_fcnt + 4'd1;
      end else if (w_lsync_rise) begin
        r_lcnt <= r_lcnt + 4'd1;
      end
    end
  end

  // Pixel phase counter. It is held at zero through blanking, so every
  // active line starts at matrix column 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= 2'd0;
    end else if (!bus.de) begin
      r_pcnt <= 2'd0;
    end else if (bus.ce_pix) begin
      r_pcnt <= r_pcnt + 2'd1;
    end
  end

  // The Bd threshold is the top D bits of the matrix entry, which is B >> (4-D).
  assign w_bayer = bayer(r_lcnt[1:0], r_pcnt);
  assign w_bd    = w_bayer[3 -: D];

  // Select the shared threshold for this pixel. The all-ones threshold can
  // never be exceeded, so mode 0 is a plain truncation.
  always_comb begin
    w_thr = '1;
    case (bus.mode)
      2'd0:    w_thr = '1;
      2'd1:    w_thr = r_lcnt[D-1:0];
      2'd2:    w_thr = w_bd;
      default: w_thr = w_bd + r_fcnt[D-1:0];
    endcase
  end

  // Split each channel into its kept bits and residue, then apply the saturating round.
  generate
    for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [OUT_W-1:0] w_q;
      logic [D-1:0]     w_r;
      assign w_q = bus.din[c*IN_W + D +: OUT_W];
      assign w_r = bus.din[c*IN_W +: D];
      assign w_pix[c*OUT_W +: OUT_W] = dither_sat(w_q, w_r, w_thr);
    end
  endgenerate

  // ---- stage p1: one register stage for pixel, syncs and de alike ----
  // Register the reduced pixel and its timing signals together. The stage
  // advances on every clock, whatever ce_pix is doing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout_p1 <= '0;
      r_hs_p1   <= 1'b0;
      r_vs_p1   <= 1'b0;
      r_cs_p1   <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_dout_p1 <= w_pix;
      r_hs_p1   <= bus.hsync;
      r_vs_p1   <= bus.vsync;
      r_cs_p1   <= bus.csync;
      r_vld_p1  <= bus.de;
    end
  end

  assign bus.dout   = r_dout_p1;
  assign bus.hs_out = r_hs_p1;
  assign bus.vs_out = r_vs_p1;
  assign bus.cs_out = r_cs_p1;
  assign bus.de_out = r_vld_p1;

endmodule

// File: tb/tb_vga_dither_pwm.sv
// Directed bench for vga_dither_pwm (CH=3, IN_W=8, OUT_W=6, D=2).
// All three channels carry the same value unless a step says otherwise.
module tb_vga_dither_pwm;
  localparam int CH    = 3;
  localparam int IN_W  = 8;
  localparam int OUT_W = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  vga_dither_pwm_if #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  vga_dither_pwm #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*IN_W-1:0] rep_in(input logic [7:0] v);
    return {CH{v}};
  endfunction

  function automatic logic [CH*OUT_W-1:0] rep_out(input logic [5:0] v);
    return {CH{v}};
  endfunction

  task automatic chk_px(input string tag, input logic [5:0] exp);
    chk(tag, 32'(bus.dout), 32'(rep_out(exp)));
  endtask

  task automatic chk_fl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, bus.hs_out, bus.vs_out, bus.cs_out, bus.de_out}, {28'd0, exp});
  endtask

  task automatic vs_pulse();
    bus.vsync = 1'b1; tick();
    bus.vsync = 1'b0; tick();
  endtask

  initial begin
    // Reset with every input high: the outputs must still be zero.
    bus.ce_pix = 1'b1; bus.mode = 2'd0; bus.csync_en = 1'b0;
    bus.hsync = 1'b1; bus.vsync = 1'b1; bus.csync = 1'b1; bus.de = 1'b1;
    bus.din = rep_in(8'h83);
    tick(); tick();
    chk_px("reset_dout", 6'h00);
    chk_fl("reset_flags", 4'b0000);

    // Mode 0 truncation. During blanking the pixel still goes through the datapath.
    reset = 1'b0;
    bus.hsync = 1'b0; bus.vsync = 1'b0; bus.csync = 1'b0; bus.de = 1'b0;
    tick();
    chk_px("m0_blank_dout", 6'h20);
    chk_fl("m0_blank_flags", 4'b0000);
    bus.de = 1'b1;
    tick();
    chk_px("m0_active_dout", 6'h20);
    chk_fl("m0_de_delay", 4'b0001);
    bus.hsync = 1'b1; tick();
    chk_fl("m0_hs_delay", 4'b1001);
    chk_px("m0_dout_hs", 6'h20);
    bus.hsync = 1'b0; tick();
    chk_fl("m0_hs_fall", 4'b0001);
    bus.vsync = 1'b1; tick();
    chk_fl("m0_vs_delay", 4'b0101);
    bus.vsync = 1'b0; tick();
    bus.csync = 1'b1; tick();
    chk_fl("m0_cs_delay", 4'b0011);
    bus.csync = 1'b0; tick();
    chk_fl("m0_cs_fall", 4'b0001);
    // lcnt=0, fcnt=1 at this point.

    // Mode 1 line PWM. The line clock is csync, so hsync is ignored.
    bus.mode = 2'd1; bus.csync_en = 1'b1; bus.de = 1'b0; bus.din = rep_in(8'h81);
    tick();
    chk_px("m1_line0", 6'h21);
    bus.hsync = 1'b1; tick();
    bus.hsync = 1'b0; tick();
    chk_px("m1_hsync_ignored", 6'h21);
    for (int k = 1; k <= 4; k++) begin
      bus.csync = 1'b1; tick();
      bus.csync = 1'b0; tick();
      chk_px($sformatf("m1_line%0d", k), (k % 4 == 0) ? 6'h21 : 6'h20);
    end
    vs_pulse();
    chk_px("m1_after_vsync", 6'h21);
    // lcnt=0, fcnt=2.

    // Mode 2 ordered dither. Line 0 thresholds are 0,2,0,2.
    bus.mode = 2'd2; bus.csync_en = 1'b0; bus.de = 1'b0; bus.din = rep_in(8'h82);
    tick();
    bus.de = 1'b1;
    for (int x = 0; x < 4; x++) begin
      tick();
      chk_px($sformatf("m2_r2_x%0d", x), (x % 2 == 0) ? 6'h21 : 6'h20);
    end
    bus.din = rep_in(8'h83);
    for (int x = 0; x < 4; x++) begin
      tick();
      chk_px($sformatf("m2_r3_x%0d", x), 6'h21);
    end
    // Line 1 thresholds are 3,1,3,1.
    bus.de = 1'b0; bus.din = rep_in(8'h82);
    bus.hsync = 1'b1; tick();
    bus.hsync = 1'b0; tick();
    bus.de = 1'b1;
    for (int x = 0; x < 4; x++) begin
      tick();
      chk_px($sformatf("m2_row1_x%0d", x), (x % 2 == 0) ? 6'h20 : 6'h21);
    end
    bus.de = 1'b0;

    // Mode 3 frame rotation at pixel (0,0) with r=1. Each iteration adds one
    // vsync edge, so fcnt goes through 3..8.
    bus.mode = 2'd3; bus.din = rep_in(8'h81);
    for (int k = 0; k < 6; k++) begin
      bus.de = 1'b0;
      vs_pulse();
      bus.de = 1'b1; tick();
      chk_px($sformatf("m3_fcnt%0d", 3 + k), (((3 + k) % 4) == 0) ? 6'h21 : 6'h20);
    end
    bus.de = 1'b0; tick();

    // Channels are independent but share one threshold (t=0 here).
    bus.mode = 2'd2; bus.din = {8'hFF, 8'h81, 8'h7E};
    tick();
    chk("m2_mixed_channels", 32'(bus.dout), 32'({6'h3F, 6'h21, 6'h20}));

    // Saturation: full scale stays at full scale in every mode and phase.
    for (int m = 0; m < 4; m++) begin
      bus.mode = 2'(m); bus.de = 1'b0; bus.din = rep_in(8'hFF);
      tick();
      bus.de = 1'b1;
      for (int x = 0; x < 4; x++) begin
        tick();
        chk_px($sformatf("sat_ff_m%0d_x%0d", m, x), 6'h3F);
      end
    end
    bus.din = rep_in(8'hFC);
    for (int m = 0; m < 4; m++) begin
      bus.mode = 2'(m); tick();
      chk_px($sformatf("sat_fc_m%0d", m), 6'h3F);
    end
    bus.mode = 2'd2; bus.de = 1'b0; bus.din = rep_in(8'hFB);
    tick();
    bus.de = 1'b1; tick();
    chk_px("sat_3e_round_up", 6'h3F);
    bus.de = 1'b0; tick();

    // Hsync and vsync rise together: the line clear wins and the frame still advances.
    bus.hsync = 1'b1; tick();
    bus.hsync = 1'b0; tick();
    bus.hsync = 1'b1; bus.vsync = 1'b1; tick();
    bus.hsync = 1'b0; bus.vsync = 1'b0; tick();
    bus.mode = 2'd1; bus.din = rep_in(8'h81); tick();
    chk_px("coincident_lcnt0", 6'h21);
    bus.mode = 2'd3; tick();
    chk_px("coincident_fcnt9", 6'h20);

    // Asynchronous reset mid-line clears everything without waiting for a clock.
    bus.mode = 2'd0; bus.din = rep_in(8'h83); bus.de = 1'b1; bus.hsync = 1'b1;
    tick(); tick();
    chk_fl("pre_reset_flags", 4'b1001);
    reset = 1'b1;
    #1;
    chk_px("async_reset_dout", 6'h00);
    chk_fl("async_reset_flags", 4'b0000);
    bus.hsync = 1'b0;
    tick();
    bus.mode = 2'd2; bus.din = rep_in(8'h82);
    reset = 1'b0;
    tick();
    chk_px("post_reset_x0", 6'h21);
    tick();
    chk_px("post_reset_x1", 6'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
